// File: rtl/mtm_alu_cmd_tx.sv
// Serial command transmitter for the mtm_Alu link: frames one (A, B, OP) command
// as DATA frames plus a CTL frame carrying OP and CRC4, with error-injection knobs.
module mtm_alu_cmd_tx #(
  parameter int IDLE_GAP = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [2:0]  cmd_op,
  input  logic [3:0]  cmd_data_cnt,
  input  logic        cmd_bad_crc,
  output logic        sout,
  output logic        busy,
  output logic        pkt_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_TYPE,
    S_PAYLOAD,
    S_STOP,
    S_GAP
  } state_t;

  localparam int GAP_W = (IDLE_GAP > 2) ? $clog2(IDLE_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((IDLE_GAP > 1) ? IDLE_GAP - 2 : 0);

  function automatic logic [3:0] crc4(input logic [67:0] msg);
    logic [3:0] c;
    logic       fb;
    c = 4'h0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ msg[i];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    end
    return c;
  endfunction

  state_t             state_q, state_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [3:0]         frm_cnt_q, frm_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [31:0]        a_q, b_q;
  logic [2:0]         op_q;
  logic [3:0]         cnt_q;
  logic [3:0]         crc_q;
  logic               sout_q, sout_d;
  logic               pkt_done_q, pkt_done_d;

  logic               accept;
  logic [63:0]        data_word;
  logic [7:0]         data_byte [8];
  logic               is_ctl_d;
  logic [7:0]         frame_byte;

  assign accept    = (state_q == S_IDLE) && cmd_valid;
  assign data_word = {b_q, a_q};

  for (genvar gi = 0; gi < 8; gi++) begin : g_bytes
    assign data_byte[gi] = data_word[63 - 8*gi -: 8];
  end

  // The IDLE cycle doubles as the last gap bit, so a held cmd_valid yields
  // exactly IDLE_GAP high bits between consecutive packets.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    frm_cnt_d  = frm_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d   = S_START;
          bit_cnt_d = 3'd0;
          frm_cnt_d = 4'd0;
          gap_cnt_d = '0;
        end
      end
      S_START: state_d = S_TYPE;
      S_TYPE: begin
        state_d   = S_PAYLOAD;
        bit_cnt_d = 3'd0;
      end
      S_PAYLOAD: begin
        if (bit_cnt_q == 3'd7) begin
          state_d = S_STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      S_STOP: begin
        if (frm_cnt_q == cnt_q) begin
          state_d   = (IDLE_GAP > 1) ? S_GAP : S_IDLE;
          gap_cnt_d = '0;
        end else begin
          state_d   = S_START;
          frm_cnt_d = frm_cnt_q + 4'd1;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    is_ctl_d = (frm_cnt_d == cnt_q);
    if (is_ctl_d) begin
      frame_byte = {1'b0, op_q, crc_q};
    end else if (frm_cnt_d[3]) begin
      frame_byte = 8'h00;
    end else begin
      frame_byte = data_byte[frm_cnt_d[2:0]];
    end

    unique case (state_d)
      S_START:   sout_d = 1'b0;
      S_TYPE:    sout_d = is_ctl_d;
      S_PAYLOAD: sout_d = frame_byte[3'd7 - bit_cnt_d];
      default:   sout_d = 1'b1;
    endcase
    pkt_done_d = (state_d == S_STOP) && is_ctl_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= 3'd0;
      frm_cnt_q  <= 4'd0;
      gap_cnt_q  <= '0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      op_q       <= 3'd0;
      cnt_q      <= 4'd0;
      crc_q      <= 4'd0;
      sout_q     <= 1'b1;
      pkt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      frm_cnt_q  <= frm_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      sout_q     <= sout_d;
      pkt_done_q <= pkt_done_d;
      if (accept) begin
        a_q   <= cmd_a;
        b_q   <= cmd_b;
        op_q  <= cmd_op;
        cnt_q <= cmd_data_cnt;
        crc_q <= crc4({cmd_b, cmd_a, 1'b1, cmd_op}) ^ {4{cmd_bad_crc}};
      end
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = ~cmd_ready;
  assign sout      = sout_q;
  assign pkt_done  = pkt_done_q;

endmodule

// File: tb/tb_mtm_alu_cmd_tx.sv
// Bench for mtm_alu_cmd_tx: table vectors, hand-written corner sequences and random
// commands checked against a frame-list reference model with long-division CRC.
module tb_mtm_alu_cmd_tx;

  localparam int IDLE_GAP = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a, cmd_b;
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_data_cnt;
  logic        cmd_bad_crc;
  logic        sout, busy, pkt_done;

  always #5 clk = ~clk;

  mtm_alu_cmd_tx #(.IDLE_GAP(IDLE_GAP)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_op      (cmd_op),
    .cmd_data_cnt(cmd_data_cnt),
    .cmd_bad_crc (cmd_bad_crc),
    .sout        (sout),
    .busy        (busy),
    .pkt_done    (pkt_done)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  bit   exp_q[$];
  logic got_q[$];
  int   last_done_cycle;

  task automatic check(input string name, input bit ok, input string detail);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  // CRC as the remainder of ({msg, 4'b0}) modulo x^4+x+1.
  function automatic logic [3:0] model_crc(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
    logic [71:0] r;
    r = {b, a, 1'b1, op, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    return r[3:0];
  endfunction

  task automatic push_frame(input bit typ, input logic [7:0] pl);
    exp_q.push_back(1'b0);
    exp_q.push_back(typ);
    for (int i = 7; i >= 0; i--) exp_q.push_back(pl[i]);
    exp_q.push_back(1'b1);
  endtask

  task automatic build_exp(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                           input logic [3:0] cnt, input logic bad);
    logic [63:0] d;
    d = {b, a};
    for (int f = 0; f < int'(cnt); f++)
      push_frame(1'b0, (f < 8) ? d[63 - 8*f -: 8] : 8'h00);
    push_frame(1'b1, {1'b0, op, model_crc(a, b, op) ^ {4{bad}}});
  endtask

  function automatic logic [7:0] got_byte(input int start);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[7 - i] = got_q[start + i];
    return v;
  endfunction

  task automatic wait_ready(output bit ok);
    for (int k = 0; k < 300 && cmd_ready !== 1'b1; k++) @(negedge clk);
    ok = (cmd_ready === 1'b1);
    if (!ok) check("wait_ready", 1'b0, "cmd_ready stayed low for 300 cycles, expected 1");
  endtask

  task automatic run_pkt(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic [3:0] cnt, input logic bad);
    int L, done_idx, done_cnt, rdy_err, gap_err, first_bad;
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    exp_q.delete();
    got_q.delete();
    build_exp(a, b, op, cnt, bad);
    L = exp_q.size();
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_data_cnt = cnt; cmd_bad_crc = bad;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid    = 1'b0;
    cmd_a        = $urandom();
    cmd_b        = $urandom();
    cmd_op       = 3'($urandom());
    cmd_data_cnt = 4'($urandom());
    cmd_bad_crc  = 1'($urandom());
    done_idx = -1; done_cnt = 0; rdy_err = 0; gap_err = 0; first_bad = -1;
    for (int i = 0; i < L; i++) begin
      got_q.push_back(sout);
      if (pkt_done === 1'b1) begin
        done_cnt++;
        if (done_idx < 0) done_idx = i;
      end
      if (cmd_ready !== 1'b0 || busy !== 1'b1) rdy_err++;
      @(negedge clk);
    end
    for (int g = 1; g <= IDLE_GAP; g++) begin
      if (sout !== 1'b1 || pkt_done !== 1'b0 || cmd_ready !== (g == IDLE_GAP) ||
          busy !== (g != IDLE_GAP)) gap_err++;
      if (g < IDLE_GAP) @(negedge clk);
    end
    for (int i = 0; i < L; i++)
      if (got_q[i] !== exp_q[i]) begin
        first_bad = i;
        break;
      end
    last_done_cycle = done_idx + 1;
    check({name, " bits"}, first_bad < 0,
          $sformatf("first bad bit at cycle %0d: got %b, expected %b", first_bad + 1,
                    (first_bad < 0) ? 1'b0 : got_q[first_bad],
                    (first_bad < 0) ? 1'b0 : exp_q[first_bad]));
    check({name, " pkt_done"}, done_cnt == 1 && done_idx == L - 1,
          $sformatf("got %0d pulses first at cycle %0d, expected 1 pulse at cycle %0d",
                    done_cnt, done_idx + 1, L));
    check({name, " busy"}, rdy_err == 0,
          $sformatf("%0d cycles with ready/busy wrong, expected 0", rdy_err));
    check({name, " gap"}, gap_err == 0,
          $sformatf("%0d bad gap cycles, expected 0", gap_err));
    $display("pkt %-10s a=%h b=%h op=%0d cnt=%0d bad=%0d len=%0d", name, a, b, op, cnt, bad, L);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [3:0]  cnt;
    logic        bad;
    logic [7:0]  exp_ctl;
    logic [63:0] exp_data;
    bit          chk_data;
    int          exp_len;
  } vec_t;

  vec_t  vt[5];
  string vname[5];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   ok;
    int   err, L, done_seen[$];
    logic [63:0] dw;
    logic [7:0]  ctl;

    vt[0] = '{32'h0, 32'h0, 3'b000, 4'd8, 1'b0, 8'h0B, 64'h0, 1'b1, 99};
    vt[1] = '{32'h0, 32'h0, 3'b000, 4'd8, 1'b1, 8'h04, 64'h0, 1'b1, 99};
    vt[2] = '{32'h01020304, 32'hA0B0C0D0, 3'b101, 4'd8, 1'b0, 8'h00,
              64'hA0B0C0D0_01020304, 1'b1, 99};
    vt[3] = '{32'h0, 32'h0, 3'b000, 4'd0, 1'b0, 8'h0B, 64'h0, 1'b0, 11};
    vt[4] = '{32'h0, 32'h0, 3'b000, 4'd10, 1'b0, 8'h0B, 64'h0, 1'b1, 121};
    vname = '{"zero_cmd", "bad_crc", "byte_order", "ctl_only", "cnt10"};

    // Reset held with cmd_valid high must not start a packet.
    rst_n = 1'b0; cmd_valid = 1'b1;
    cmd_a = 32'hFFFF_FFFF; cmd_b = 32'h1234_5678; cmd_op = 3'b111;
    cmd_data_cnt = 4'd8; cmd_bad_crc = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("reset_hold%0d", c),
            sout === 1'b1 && cmd_ready === 1'b1 && busy === 1'b0 && pkt_done === 1'b0,
            $sformatf("sout=%b ready=%b busy=%b done=%b, expected 1 1 0 0",
                      sout, cmd_ready, busy, pkt_done));
    end
    rst_n = 1'b1; cmd_valid = 1'b0;
    err = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (sout !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0) err++;
    end
    check("reset_release", err == 0, $sformatf("%0d non-idle cycles, expected 0", err));

    for (int v = 0; v < 5; v++) begin
      run_pkt(vname[v], vt[v].a, vt[v].b, vt[v].op, vt[v].cnt, vt[v].bad);
      L   = got_q.size();
      ctl = got_byte(L - 9);
      check({vname[v], " ctl"}, vt[v].op != 3'b000 || ctl === vt[v].exp_ctl,
            $sformatf("ctl payload %h, expected %h", ctl, vt[v].exp_ctl));
      check({vname[v], " length"}, last_done_cycle == vt[v].exp_len,
            $sformatf("pkt_done at cycle %0d, expected %0d", last_done_cycle, vt[v].exp_len));
      if (vt[v].chk_data) begin
        for (int k = 0; k < 8; k++) dw[63 - 8*k -: 8] = got_byte(k*11 + 2);
        check({vname[v], " data"}, dw === vt[v].exp_data,
              $sformatf("data bytes %h, expected %h", dw, vt[v].exp_data));
      end
    end

    // Held cmd_valid: three packets separated by exactly IDLE_GAP high bits.
    wait_ready(ok);
    if (ok) begin
      cmd_a = $urandom(); cmd_b = $urandom(); cmd_op = 3'($urandom());
      cmd_data_cnt = 4'd0; cmd_bad_crc = 1'b0;
      exp_q.delete(); got_q.delete(); done_seen.delete();
      for (int p = 0; p < 3; p++) begin
        build_exp(cmd_a, cmd_b, cmd_op, 4'd0, 1'b0);
        if (p < 2) for (int g = 0; g < IDLE_GAP; g++) exp_q.push_back(1'b1);
      end
      L = exp_q.size();
      cmd_valid = 1'b1;
      @(negedge clk);
      for (int i = 0; i < L; i++) begin
        got_q.push_back(sout);
        if (pkt_done === 1'b1) done_seen.push_back(i + 1);
        if (i == L - 1) cmd_valid = 1'b0;
        @(negedge clk);
      end
      err = 0;
      for (int i = 0; i < L; i++) if (got_q[i] !== exp_q[i]) err++;
      check("held_valid stream", err == 0,
            $sformatf("%0d wrong bits of %0d, expected 0", err, L));
      check("held_valid pkt_done",
            done_seen.size() == 3 && done_seen[0] == 11 && done_seen[1] == 24 &&
            done_seen[2] == 37,
            $sformatf("%0d pulses, expected 3 at cycles 11,24,37", done_seen.size()));
      $display("pkt held_valid x3 a=%h b=%h op=%0d len=%0d", cmd_a, cmd_b, cmd_op, L);
    end

    // Reset in the middle of a payload aborts at the next edge.
    wait_ready(ok);
    if (ok) begin
      cmd_a = 32'h0; cmd_b = 32'h0; cmd_op = 3'b000; cmd_data_cnt = 4'd8; cmd_bad_crc = 1'b0;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int c = 1; c < 15; c++) @(negedge clk);
      check("midreset pre", sout === 1'b0 && busy === 1'b1,
            $sformatf("sout=%b busy=%b, expected 0 1", sout, busy));
      rst_n = 1'b0;
      @(negedge clk);
      check("midreset abort",
            sout === 1'b1 && cmd_ready === 1'b1 && busy === 1'b0 && pkt_done === 1'b0,
            $sformatf("sout=%b ready=%b busy=%b done=%b, expected 1 1 0 0",
                      sout, cmd_ready, busy, pkt_done));
      rst_n = 1'b1;
      err = 0;
      for (int c = 0; c < 15; c++) begin
        @(negedge clk);
        if (sout !== 1'b1 || cmd_ready !== 1'b1 || pkt_done !== 1'b0) err++;
      end
      check("midreset idle", err == 0, $sformatf("%0d non-idle cycles, expected 0", err));
      $display("pkt midreset  aborted in payload of frame 2");
    end

    for (int k = 0; k < 24; k++)
      run_pkt($sformatf("rand%0d", k), $urandom(), $urandom(), 3'($urandom()),
              4'($urandom_range(0, 15)), 1'($urandom()));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
